toggle_pulse_gen: RTL
=====================

// Module: toggle_pulse_gen
// PURPOSE
//  Upstream stage for the T flip-flop. Takes a raw, bouncy, asynchronous pushbutton and
//  emits a clean one-cycle t_pulse per debounced press. t_pulse drives the flip-flop T input,
//  so Q toggles exactly once per press. Also exports the debounced button level.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive synced-high (or -low) cycles required to accept a press (release); >=2
//  REPEAT_DELAY     16  cycles in HELD before the first auto-repeat pulse (AUTO_REPEAT_EN only); >=2
//  REPEAT_PERIOD    8   cycles between subsequent auto-repeat pulses (AUTO_REPEAT_EN only); >=2
//  CNT_W            8   counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)
// PORTS
//  clk        in   1  single system clock, rising edge
//  rst        in   1  synchronous, active-high reset
//  btn        in   1  raw button, asynchronous to clk, may bounce
//  t_pulse    out  1  one-cycle press pulse; connects to flip-flop T
//  btn_level  out  1  debounced button level
// BEHAVIOUR
//  - Reset (sync, active-high): sync flops=0, state=IDLE, counters=0, t_pulse=0, btn_level=0.
//  - btn passes through a 2-flop synchronizer -> btn_s (2-cycle delay). FSM sees only btn_s.
//  - FSM states (tff_pkg::state_t): IDLE, PRESS_CHK, HELD, REL_CHK.
//    IDLE:      btn_s=1 -> PRESS_CHK, cnt=0.
//    PRESS_CHK: btn_s=0 -> IDLE (bounce rejected, no pulse); else cnt++; at cnt==DEBOUNCE_CYCLES-1
//               with btn_s=1 -> HELD, register t_pulse=1 and btn_level=1 on that same edge.
//    HELD:      btn_s=0 -> REL_CHK, cnt=0; otherwise stay.
//    REL_CHK:   btn_s=1 -> HELD (glitch; no new pulse, btn_level stays 1); else cnt++; at
//               cnt==DEBOUNCE_CYCLES-1 -> IDLE, btn_level=0.
//  - Latency: t_pulse rises DEBOUNCE_CYCLES+2 edges after the edge that first samples btn=1
//    (stable). Width is exactly 1 cycle. t_pulse is never high on two consecutive cycles.
//  - btn_level falls DEBOUNCE_CYCLES+2 edges after the edge that first samples a stable btn=0.
//  - Counters saturate and never wrap. All outputs are registered; no combinational path from btn.
//  - Reset mid-operation: the FSM returns to IDLE immediately and all progress is discarded.
//    If btn is still high after reset, it is a new press and yields a pulse after the full latency.
//  - rst dominates every other event on the same edge.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: in HELD, rep_cnt counts from 0 on HELD entry. It emits an extra
//    t_pulse after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles while still in HELD.
//    rep_cnt is frozen in REL_CHK and cleared on return from REL_CHK to HELD.
//  AUTO_REPEAT_EN undefined: no rep_cnt logic; exactly one t_pulse per accepted press.
// STRUCTURE
//  - tff_pkg: state_t enum (IDLE=2'd0, PRESS_CHK=2'd1, HELD=2'd2, REL_CHK=2'd3) and default
//    parameter constants, shared with the flip-flop benches.
//  - Sub-module sync_2ff (1-bit, clk/rst, 2 flops, reset to 0): reusable synchronizer.
//  - Top: FSM, debounce counter, optional repeat counter, output registers.
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=8; DUT t_pulse -> tflipflop T)
//  1 rst=1 for 10 cycles with btn=1 -> t_pulse=0, btn_level=0, Q=0 throughout.
//  2 Clean press: btn 0->1, held 20 cycles -> one t_pulse 6 edges after first sampling edge;
//    btn_level=1 on the same cycle; Q toggles 0->1 once.
//  3 Bounce: btn 1,1,0,1,0,1,1 (per cycle), then stable 1 -> no pulse during bounce; one pulse
//    6 edges after the stable-1 run begins.
//  4 Release glitch: in HELD, btn=0 for 2 cycles then 1 -> btn_level stays 1, no pulse, Q unchanged;
//    full release later -> btn_level=0 6 edges after btn falls.
//  5 rst pulsed for 1 cycle 3 cycles into PRESS_CHK, btn kept 1 -> no pulse before reset;
//    one pulse 6 edges after the first post-reset edge.
//  6 btn held 60 cycles -> with AUTO_REPEAT_EN: pulses at t0, t0+16, t0+24, t0+32, ...
//    Without AUTO_REPEAT_EN: a single pulse at t0 only.

Source files
------------

// File: rtl/tff_pkg.sv
// Shared types and default constants for the T flip-flop front end (pulse generator and benches).
package tff_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_CHK = 2'd1,
      HELD      = 2'd2,
      REL_CHK   = 2'd3
   } state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int DEF_REPEAT_DELAY    = 16;
   localparam int DEF_REPEAT_PERIOD   = 8;
   localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both stages clear on rst.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_p0;
   logic sync_p1;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         meta_p0 <= d;
         sync_p1 <= meta_p0;
      end
   end

   assign q = sync_p1;

endmodule

// File: rtl/toggle_pulse_gen.sv
// Debounced pushbutton to one-cycle toggle pulse, plus debounced level output.
// Optional build macro AUTO_REPEAT_EN adds auto-repeat pulses while the button is held.
module toggle_pulse_gen
   import tff_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic t_pulse,
   output logic btn_level
);

   localparam int MAX_CNT = (DEBOUNCE_CYCLES > REPEAT_DELAY)
                            ? ((DEBOUNCE_CYCLES > REPEAT_PERIOD) ? DEBOUNCE_CYCLES : REPEAT_PERIOD)
                            : ((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);

   // Elaboration-time guard on the parameter set.
   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 ||
       MAX_CNT > (1 << CNT_W) - 1) begin : g_bad_cfg
      $error("toggle_pulse_gen: bad parameter set");
   end

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   logic             btn_s;
   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             pulse_n;
   logic             level_n;

`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] REP_PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

   logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
   logic             rep_first, rep_first_n;
   logic [CNT_W-1:0] rep_last;

   // First repeat waits the long delay, later ones the shorter period.
   assign rep_last = rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST;
`endif

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn),
      .q   (btn_s)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      pulse_n = 1'b0;
      level_n = btn_level;
`ifdef AUTO_REPEAT_EN
      rep_cnt_n   = rep_cnt;
      rep_first_n = rep_first;
`endif
      case (state)
         IDLE: begin
            if (btn_s) begin
               state_n = PRESS_CHK;
               cnt_n   = '0;
            end
         end
         PRESS_CHK: begin
            if (!btn_s) begin
               state_n = IDLE;
            end else if (cnt == DEB_LAST) begin
               state_n = HELD;
               pulse_n = 1'b1;
               level_n = 1'b1;
`ifdef AUTO_REPEAT_EN
               rep_cnt_n   = '0;
               rep_first_n = 1'b1;
`endif
            end else begin
               cnt_n = sat_inc(cnt);
            end
         end
         HELD: begin
            if (!btn_s) begin
               state_n = REL_CHK;
               cnt_n   = '0;
            end
`ifdef AUTO_REPEAT_EN
            else if (rep_cnt == rep_last) begin
               pulse_n     = 1'b1;
               rep_cnt_n   = '0;
               rep_first_n = 1'b0;
            end else begin
               rep_cnt_n = sat_inc(rep_cnt);
            end
`endif
         end
         REL_CHK: begin
            // A short low glitch returns to HELD without a new pulse.
            if (btn_s) begin
               state_n = HELD;
`ifdef AUTO_REPEAT_EN
               rep_cnt_n   = '0;
               rep_first_n = 1'b1;
`endif
            end else if (cnt == DEB_LAST) begin
               state_n = IDLE;
               level_n = 1'b0;
            end else begin
               cnt_n = sat_inc(cnt);
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         t_pulse   <= 1'b0;
         btn_level <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         t_pulse   <= pulse_n;
         btn_level <= level_n;
      end
   end

`ifdef AUTO_REPEAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt   <= '0;
         rep_first <= 1'b1;
      end else begin
         rep_cnt   <= rep_cnt_n;
         rep_first <= rep_first_n;
      end
   end
`endif

endmodule
